// File: rtl/multiplier_ieee754_pkg.sv
// Shared definitions for the binary32 multiplier core.
// Contents: FSM state encoding, binary32 field widths and bias, the canonical
// quiet NaN and +Inf encodings, and helpers that slice a binary32 word into
// its sign, biased exponent and fraction fields.
package multiplier_ieee754_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int          BIAS    = 127;
  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [FRAC_W-1:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/multiplier_ieee754_round.sv
// Round-to-nearest, ties-to-even for a normalised 24-bit significand.
// Ports:
//   sig    - normalised significand, hidden bit in sig[23]
//   guard  - first bit below the LSB
//   sticky - OR of every bit below the guard bit
//   frac   - rounded 23-bit fraction (wraps to 0 on carry)
//   carry  - rounding overflowed the significand; exponent must step by one
module multiplier_ieee754_round
  import multiplier_ieee754_pkg::*;
(
  input  logic [23:0]       sig,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic round_up;

  // Increment when above half, or exactly half with an odd LSB.
  assign round_up = guard & (sticky | sig[0]);

  // Fraction wraps to zero when all ones are incremented; that is exactly
  // the carry case, where the renormalised value is 1.0 * 2^(exp+1).
  assign frac  = sig[FRAC_W-1:0] + {{(FRAC_W-1){1'b0}}, round_up};
  assign carry = round_up & (&sig);

endmodule

// File: rtl/multiplier_ieee754_core.sv
// Multi-cycle binary32 multiplier driven by a level request.
// Flow: IDLE latches operands on in_rdy, then CHECK / MULT / NORM / ROUND
// each take one edge, and DONE presents the product until in_rdy drops.
// Latency is fixed at 5 edges from the sampling edge to res_rdy for every
// input, special cases included. Denormal inputs are flushed to zero and
// results that would be denormal are flushed to signed zero.
// Ports:
//   pclk    - clock, rising edge
//   presetn - synchronous active-low reset, clears all state
//   op1/op2 - binary32 operands, sampled only in IDLE
//   in_rdy  - operands valid; held high by the requester until res_rdy
//   res     - registered binary32 product
//   res_rdy - registered, high while the result is presented
module multiplier_ieee754_core
  import multiplier_ieee754_pkg::*;
#(
  parameter int SIZE = 32  // only binary32 is supported
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic [SIZE-1:0] op1,
  input  logic [SIZE-1:0] op2,
  input  logic            in_rdy,
  output logic [SIZE-1:0] res,
  output logic            res_rdy
);

  state_t state_q, state_d;

  logic [SIZE-1:0]         a_q, b_q;
  logic                    sign_q;
  logic signed [9:0]       exp_q;
  logic [23:0]             m1_q, m2_q;
  logic [47:0]             prod_q;
  logic [23:0]             sig_q;
  logic                    guard_q, sticky_q;
  logic                    spec_q;
  logic [31:0]             spec_val_q;

  // Operand classification, consumed in CHECK.
  logic [EXP_W-1:0]  e1, e2;
  logic [FRAC_W-1:0] f1, f2;
  logic              sign_c;
  logic              nan1, nan2, inf1, inf2, zero1, zero2;
  logic              spec_c;
  logic [31:0]       spec_val_c;

  always_comb begin
    e1         = f_exp(a_q);
    e2         = f_exp(b_q);
    f1         = f_frac(a_q);
    f2         = f_frac(b_q);
    sign_c     = f_sign(a_q) ^ f_sign(b_q);
    nan1       = (e1 == 8'hFF) && (f1 != '0);
    nan2       = (e2 == 8'hFF) && (f2 != '0);
    inf1       = (e1 == 8'hFF) && (f1 == '0);
    inf2       = (e2 == 8'hFF) && (f2 == '0);
    // A zero exponent covers both true zeros and denormals.
    zero1      = (e1 == '0);
    zero2      = (e2 == '0);
    spec_c     = 1'b0;
    spec_val_c = '0;
    if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) begin
      spec_c     = 1'b1;
      spec_val_c = QNAN;
    end else if (inf1 || inf2) begin
      spec_c     = 1'b1;
      spec_val_c = {sign_c, POS_INF[30:0]};
    end else if (zero1 || zero2) begin
      spec_c     = 1'b1;
      spec_val_c = {sign_c, 31'd0};
    end
  end

  // Rounding and final exponent range, consumed in ROUND.
  logic [FRAC_W-1:0] frac_rnd;
  logic              carry_rnd;
  logic signed [9:0] exp_fin;
  logic [31:0]       res_c;

  multiplier_ieee754_round u_round (
    .sig    (sig_q),
    .guard  (guard_q),
    .sticky (sticky_q),
    .frac   (frac_rnd),
    .carry  (carry_rnd)
  );

  always_comb begin
    exp_fin = exp_q + $signed({9'd0, carry_rnd});
    res_c   = '0;
    if (spec_q) begin
      res_c = spec_val_q;
    end else if (exp_fin >= 10'sd255) begin
      res_c = {sign_q, POS_INF[30:0]};
    end else if (exp_fin <= 10'sd0) begin
      res_c = {sign_q, 31'd0};
    end else begin
      res_c = {sign_q, exp_fin[EXP_W-1:0], frac_rnd};
    end
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; DONE waits for the requester to release in_rdy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_rdy) state_d = CHECK;
      CHECK:   state_d = MULT;
      MULT:    state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (!in_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers, advanced one step per state.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      prod_q     <= '0;
      sig_q      <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      res        <= '0;
      res_rdy    <= 1'b0;
    end else begin
      res_rdy <= (state_q == DONE) && in_rdy;
      case (state_q)
        // IDLE: capture operands on request
        IDLE: begin
          if (in_rdy) begin
            a_q <= op1;
            b_q <= op2;
          end
        end
        // CHECK: unpack, biased exponent sum, special-case classification
        CHECK: begin
          sign_q     <= sign_c;
          exp_q      <= $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
          m1_q       <= {1'b1, f1};
          m2_q       <= {1'b1, f2};
          spec_q     <= spec_c;
          spec_val_q <= spec_val_c;
        end
        // MULT: full 48-bit significand product
        MULT: begin
          prod_q <= m1_q * m2_q;
        end
        // NORM: product lies in [1,4); bring it to [1,2) and split off G/S
        NORM: begin
          if (prod_q[47]) begin
            sig_q    <= prod_q[47:24];
            guard_q  <= prod_q[23];
            sticky_q <= |prod_q[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            sig_q    <= prod_q[46:23];
            guard_q  <= prod_q[22];
            sticky_q <= |prod_q[21:0];
          end
        end
        // ROUND: RNE, range clamp, special-case override
        ROUND: begin
          res <= res_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multiplier_ieee754_core.md
MULTIPLIER_IEEE754_CORE -- requirements
Module: multiplier_ieee754_core

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, the operand and result width; only 32 (binary32) is supported.
REQ-002 The block SHALL have port pclk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port presetn, input, 1, the reset: synchronous and active-low.
REQ-004 The block SHALL have port op1, input, SIZE, the first binary32 operand.
REQ-005 The block SHALL have port op2, input, SIZE, the second binary32 operand.
REQ-006 The block SHALL have port in_rdy, input, 1, a level request meaning the operands are valid; the upstream APB wrapper holds it high until res_rdy.
REQ-007 The block SHALL have port res, output, SIZE, the binary32 product, registered.
REQ-008 The block SHALL have port res_rdy, output, 1, meaning res is valid, registered.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, CHECK, MULT, NORM, ROUND and DONE.
REQ-010 In IDLE with in_rdy=1 at an edge, the block SHALL latch op1/op2 into internal registers and go to CHECK; otherwise it SHALL stay in IDLE.
REQ-011 CHECK SHALL unpack sign/exponent/mantissa, form sign = s1 XOR s2, compute exp = e1+e2-127 in 10-bit signed, and classify the special cases, then go to MULT.
REQ-012 MULT SHALL form the 48-bit product of the 24-bit significands (hidden bit set), then go to NORM.
REQ-013 NORM SHALL shift right by 1 and increment exp if product bit 47 is set, extract the 23-bit fraction, guard bit and sticky bit (OR of the remaining lower bits), then go to ROUND.
REQ-014 ROUND SHALL round to nearest, ties to even; a carry out of the fraction SHALL renormalise (fraction=0, exp+1); it SHALL then go to DONE.
REQ-015 Latency SHALL be fixed for all inputs, including special cases: res_rdy SHALL rise 5 edges after the edge that samples in_rdy in IDLE.
REQ-016 In DONE the block SHALL hold res_rdy=1 and res stable while in_rdy=1, and SHALL return to IDLE with res_rdy=0 on the first edge where in_rdy=0; res SHALL keep its last value.
REQ-017 in_rdy toggling in CHECK to ROUND SHALL be ignored; operands SHALL be sampled only in IDLE.
REQ-018 For NaN operands, or Inf times zero, the block SHALL output 0x7FC00000 (canonical qNaN).
REQ-019 For Inf times a non-zero finite value or Inf, the block SHALL output a signed Inf (exponent 0xFF, fraction 0).
REQ-020 Denormal inputs SHALL be treated as signed zero, and zero times a finite value SHALL give a signed zero.
REQ-021 A final exp of 255 or more after rounding SHALL give a signed Inf, and a final exp of 0 or less SHALL give a signed zero (no denormal outputs).
REQ-022 Special-case results SHALL override the datapath result at ROUND.

Reset
REQ-023 When presetn=0 at an edge, the block SHALL set the state to IDLE, res_rdy=0, res=0 and clear all internal registers, in any state including mid-operation.
REQ-024 After reset release, the first operation SHALL start only on a new in_rdy=1 sample in IDLE.

Structure
REQ-025 Package multiplier_ieee754_pkg SHALL hold the state encoding, BIAS=127, EXP_W=8, FRAC_W=23, QNAN=0x7FC00000, POS_INF=0x7F800000 and the field-slice helpers.
REQ-026 The RNE rounding logic SHALL be one combinational sub-module, multiplier_ieee754_round: 24-bit significand, guard and sticky in; rounded fraction and carry out.
REQ-027 The block SHALL be a drop-in for the APB wrapper's multiplier instance, with the same op1/op2/in_rdy/res/res_rdy semantics.

Verification
REQ-028 The bench SHALL drive 0x40000000 x 0x40400000 with in_rdy held and require res=0x40C00000 with res_rdy rising exactly 5 edges after the sample.
REQ-029 The bench SHALL drive 0xC0000000 x 0x40400000 and require 0xC0C00000, then 0x3FC00000 x 0x3FC00000 and require 0x40100000.
REQ-030 The bench SHALL drive 0x3F800001 x 0x3F800001 (rounding) and require 0x3F800002.
REQ-031 The bench SHALL drive 0x7F800000 x 0x00000000 and require 0x7FC00000; 0xFF800000 x 0x40000000 and require 0xFF800000; 0x7F7FFFFF x 0x40000000 and require 0x7F800000; 0x00800000 x 0x00800000 and require 0x00000000.
REQ-032 The bench SHALL hold in_rdy after DONE and require res_rdy to stay 1 with res stable; dropping in_rdy SHALL give res_rdy=0 on the next edge and a new op accepted 1 edge later.
REQ-033 The bench SHALL assert presetn=0 during MULT and require res_rdy=0 and res=0 next edge and state IDLE; then 0x40000000 x 0x40000000 SHALL give 0x40800000.
